// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use, branch flush,
// multi-cycle mul/div freeze and SYSCALL halt, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_wbregnum,
  input  logic        ex_branch_taken,
  input  logic        ex_muldiv_start,
  input  logic        wb_syscall,
  input  logic        resume,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_clr,
  output logic        memwb_clr,
  output logic        idex_bb,
  output logic        exmem_bb,
  output logic        muldiv_busy,
  output logic        halted,
  output logic [15:0] stall_cycles,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // The entry cycle is the first frozen cycle, so the counter starts one short.
  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_stall_cycles;
  logic        w_load_use;
  logic        w_freeze;

  assign w_load_use = ex_memtoreg & ex_regwrite & (ex_wbregnum != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_wbregnum)) |
                       (id_uses_rt & (id_rt == ex_wbregnum)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_cnt          <= 4'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!pc_en && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_clr    = 1'b0;
    memwb_clr   = 1'b0;
    idex_bb     = 1'b0;
    exmem_bb    = 1'b0;
    muldiv_busy = 1'b0;
    w_freeze    = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      ST_HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        if (resume)
          w_state_nxt = ST_RUN;
      end

      ST_MULDIV: begin
        muldiv_busy = 1'b1;
        if (r_cnt != 4'd0) begin
          w_freeze  = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Release cycle: the mul/div result leaves EX with normal enables.
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        if (wb_syscall) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_clr   = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (ex_muldiv_start) begin
          muldiv_busy = 1'b1;
          w_freeze    = 1'b1;
          w_cnt_nxt   = LAT_M1;
          w_state_nxt = ST_MULDIV;
        end else if (ex_branch_taken) begin
          ifid_clr = 1'b1;
          idex_bb  = 1'b1;
        end else if (w_load_use) begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          idex_bb = 1'b1;
        end
      end
    endcase

    // Freeze front end; EX/MEM takes a bubble while older instructions drain.
    if (w_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_bb = 1'b1;
    end
  end

  assign halted       = (r_state == ST_HALT);
  assign stall_cycles = r_stall_cycles;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MULDIV_LAT = 4).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_wbregnum;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_memtoreg, ex_regwrite, ex_branch_taken, ex_muldiv_start;
  logic        wb_syscall, resume;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_clr, memwb_clr, idex_bb, exmem_bb;
  logic        muldiv_busy, halted;
  logic [15:0] stall_cycles;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_stall = 16'd0;

  // {pc,ifid,idex,exmem,memwb en | ifid_clr,memwb_clr | idex_bb,exmem_bb | busy,halted}
  localparam logic [10:0] V_DEF = 11'b11111_00_00_0_0;
  localparam logic [10:0] V_LU  = 11'b00111_00_10_0_0;
  localparam logic [10:0] V_BR  = 11'b11111_10_10_0_0;
  localparam logic [10:0] V_FRZ = 11'b00011_00_01_1_0;
  localparam logic [10:0] V_MDX = 11'b11111_00_00_1_0;
  localparam logic [10:0] V_SYS = 11'b00001_01_00_0_0;
  localparam logic [10:0] V_HLT = 11'b00000_00_00_0_1;

  logic [10:0] obs_vec;
  assign obs_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_clr, memwb_clr, idex_bb, exmem_bb, muldiv_busy, halted};

  pipeline_hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_wbregnum(ex_wbregnum),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .wb_syscall(wb_syscall), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_clr(ifid_clr), .memwb_clr(memwb_clr),
    .idex_bb(idex_bb), .exmem_bb(exmem_bb), .muldiv_busy(muldiv_busy),
    .halted(halted), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memtoreg = 1'b0; ex_regwrite = 1'b0; ex_wbregnum = 5'd0;
    ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0; wb_syscall = 1'b0; resume = 1'b0;
  endtask

  // Inputs already applied at the negedge; check, advance one edge, update model.
  task automatic step(input string tag, input logic [10:0] exp_vec);
    #1;
    check({tag, ".out"}, 32'(obs_vec), 32'(exp_vec));
    check({tag, ".stall"}, 32'(stall_cycles), 32'(exp_stall));
    @(posedge clk);
    if (!exp_vec[10] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    check("rst.out", 32'(obs_vec), 32'(V_DEF));
    check("rst.stall", 32'(stall_cycles), 32'd0);
    check("rst.state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", V_DEF);

    // Load-use on rs, then on rt
    ex_memtoreg = 1; ex_regwrite = 1; ex_wbregnum = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    step("lu_rs", V_LU);
    clear_inputs();
    step("lu_rs_after", V_DEF);
    ex_memtoreg = 1; ex_regwrite = 1; ex_wbregnum = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
    id_rs = 5'd3; id_uses_rs = 1;
    step("lu_rt", V_LU);

    // Non-hazards: r0 destination, unused source, no regwrite, not a load
    clear_inputs();
    ex_memtoreg = 1; ex_regwrite = 1; ex_wbregnum = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    step("lu_r0", V_DEF);
    ex_wbregnum = 5'd9; id_rs = 5'd9; id_uses_rs = 0;
    step("lu_unused", V_DEF);
    id_uses_rs = 1; ex_regwrite = 0;
    step("lu_noregw", V_DEF);
    ex_regwrite = 1; ex_memtoreg = 0;
    step("lu_noload", V_DEF);

    // Branch wins over load-use
    ex_memtoreg = 1; ex_branch_taken = 1;
    step("br_lu", V_BR);
    clear_inputs();

    // Mul/div held high: 4 frozen, 1 release, no re-trigger; branch/load-use ignored
    ex_muldiv_start = 1;
    step("md0", V_FRZ);
    check("md.state", 32'(dbg_state), 32'd1);
    ex_branch_taken = 1;
    step("md1", V_FRZ);
    ex_memtoreg = 1; ex_regwrite = 1; ex_wbregnum = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
    step("md2", V_FRZ);
    step("md3", V_FRZ);
    step("md_rel", V_MDX);
    clear_inputs();
    step("md_after", V_DEF);

    // Syscall beats mul/div and branch; halt ignores syscall; resume cycle still frozen
    wb_syscall = 1; ex_muldiv_start = 1; ex_branch_taken = 1;
    step("sys", V_SYS);
    check("sys.state", 32'(dbg_state), 32'd2);
    step("halt0", V_HLT);
    clear_inputs();
    step("halt1", V_HLT);
    resume = 1;
    step("resume", V_HLT);
    resume = 0;
    step("post_halt", V_DEF);

    // Reset during the 2nd MULDIV cycle
    ex_muldiv_start = 1;
    step("mdr0", V_FRZ);
    step("mdr1", V_FRZ);
    clear_inputs();
    rst_n = 1'b0;
    exp_stall = 16'd0;
    #1;
    check("mdr_rst.busy", 32'(muldiv_busy), 32'd0);
    check("mdr_rst.stall", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("mdr_post", V_DEF);
    check("mdr_post.state", 32'(dbg_state), 32'd0);

    // Reset during HALT
    wb_syscall = 1;
    step("hr_sys", V_SYS);
    clear_inputs();
    step("hr_halt", V_HLT);
    rst_n = 1'b0;
    exp_stall = 16'd0;
    #1;
    check("hr_rst.halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("hr_post", V_DEF);

    // Saturation: sit in HALT for 70000 frozen cycles
    wb_syscall = 1;
    step("sat_sys", V_SYS);
    clear_inputs();
    repeat (70000) @(posedge clk);
    @(negedge clk);
    exp_stall = 16'hFFFF;
    step("sat_hold", V_HLT);
    check("sat_again", 32'(stall_cycles), 32'hFFFF);
    resume = 1;
    step("sat_resume", V_HLT);
    resume = 0;
    step("sat_post", V_DEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
